// File: rtl/cap_err_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : cap_err_scoreboard
// Description : Checks that every fault forced by the CHERI load/store
//               capability error injector is answered by a matching trap
//               within TIMEOUT cycles. Counts injected, detected and missed
//               faults and keeps a sticky failure flag.
//               Optional feature macro: CAP_ERR_SCOREBOARD_TVAL_EN
//               (when defined, cause-28 traps must also carry the expected
//               CHERI cause code in mtval[4:0]).
// Revision    : 1.0 - initial release
// ============================================================================
module cap_err_scoreboard #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_enable,
    input  logic             err_active,
    input  logic             err_failed,
    input  logic             exp_cause_vld,
    input  logic [4:0]       exp_cause,
    input  logic             exc_valid,
    input  logic [5:0]       exc_mcause,
    input  logic [31:0]      exc_mtval,
    output logic [1:0]       chk_state,
    output logic [CNT_W-1:0] inj_cnt,
    output logic [CNT_W-1:0] det_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             mismatch_pulse,
    output logic             chk_fail
);

    localparam int         TIMER_W  = $clog2(TIMEOUT);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [5:0] MCAUSE_CHERI    = 6'd28;
    localparam logic [5:0] MCAUSE_LD_ALIGN = 6'd4;
    localparam logic [5:0] MCAUSE_ST_ALIGN = 6'd6;

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               err_active_q;
    logic               cause_vld_q, cause_vld_d;
    logic [CNT_W-1:0]   inj_cnt_q, inj_cnt_d;
    logic [CNT_W-1:0]   det_cnt_q, det_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               pulse_q, pulse_d;
    logic               fail_q, fail_d;

    logic w_rise;
    logic w_armed;
    logic w_code_ok;
    logic w_cause_ok;
    logic w_hit;
    logic w_miss;
    logic w_unused_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef CAP_ERR_SCOREBOARD_TVAL_EN
    logic [4:0] cause_q, cause_d;

    // Latch the expected CHERI cause code when an injection is armed
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= 5'd0;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign cause_d       = (state_q == S_IDLE && err_enable && w_rise) ? exp_cause : cause_q;
    // An unknown expected code (vld=0) accepts any CHERI trap
    assign w_code_ok     = ~cause_vld_q | (exc_mtval[4:0] == cause_q);
    assign w_unused_bits = ^exc_mtval[31:5];
`else
    assign w_code_ok     = 1'b1;
    assign w_unused_bits = ^{exc_mtval, exp_cause};
`endif

    // Alignment traps only count when the injection carried no CHERI code
    assign w_rise     = err_active & ~err_active_q;
    assign w_cause_ok = ((exc_mcause == MCAUSE_CHERI) & w_code_ok) |
                        (((exc_mcause == MCAUSE_LD_ALIGN) | (exc_mcause == MCAUSE_ST_ALIGN)) & ~cause_vld_q);

    // Event decode for the ARMED state; err_failed outranks any trap, and
    // a disabled injector suppresses every outcome
    assign w_armed = (state_q == S_ARMED) & err_enable;
    assign w_hit   = w_armed & ~err_failed & exc_valid & w_cause_ok;
    assign w_miss  = w_armed & (err_failed |
                                (exc_valid & ~w_cause_ok) |
                                (~exc_valid & (timer_q == TIMER_W'(TIMEOUT - 1))));

    // State, timer, counter and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            err_active_q <= 1'b0;
            cause_vld_q  <= 1'b0;
            inj_cnt_q    <= '0;
            det_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            pulse_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            err_active_q <= err_active;
            cause_vld_q  <= cause_vld_d;
            inj_cnt_q    <= inj_cnt_d;
            det_cnt_q    <= det_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            pulse_q      <= pulse_d;
            fail_q       <= fail_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!err_enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (w_rise)          state_d = S_ARMED;
                S_ARMED:  if (w_hit || w_miss) state_d = S_REPORT;
                S_REPORT: if (!err_active)     state_d = S_IDLE;
                default:                       state_d = S_IDLE;
            endcase
        end
    end

    // Timer, counters and report flags for the next cycle
    always_comb begin
        timer_d     = timer_q;
        cause_vld_d = cause_vld_q;
        inj_cnt_d   = inj_cnt_q;
        det_cnt_d   = det_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        pulse_d     = 1'b0;
        fail_d      = fail_q;
        if (state_q == S_IDLE && err_enable && w_rise) begin
            inj_cnt_d   = sat_inc(inj_cnt_q);
            cause_vld_d = exp_cause_vld;
            timer_d     = '0;
        end
        if (w_armed) begin
            timer_d = timer_q + TIMER_W'(1);
        end
        if (w_hit) begin
            det_cnt_d = sat_inc(det_cnt_q);
        end
        if (w_miss) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
            pulse_d    = 1'b1;
            fail_d     = 1'b1;
        end
    end

    assign chk_state      = state_q;
    assign inj_cnt        = inj_cnt_q;
    assign det_cnt        = det_cnt_q;
    assign miss_cnt       = miss_cnt_q;
    assign mismatch_pulse = pulse_q;
    assign chk_fail       = fail_q;

endmodule
`default_nettype wire

// File: doc/cap_err_scoreboard.md
# cap_err_scoreboard

Testbench-side checker that consumes the error-injection status produced by the CHERI load/store capability error generator. It also watches the core's trap interface and confirms that every injected capability fault produces a matching exception within a bounded window. It counts injected, detected and missed faults, and raises a sticky failure flag for the bench's end-of-test check. It is clocked RTL so the bench and emulation builds can share it.

## Interface
Parameters:
- TIMEOUT, 64: cycles allowed from injection to trap; must be ≥ 2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- err_enable  in  1  injection globally enabled.
- err_active  in  1  injector is currently forcing a fault.
- err_failed  in  1  injector saw an LSU request leave without a CHERI error flagged.
- exp_cause_vld  in  1  exp_cause is meaningful for the current injection.
- exp_cause  in  5  expected CHERI cause code (mtval[4:0]); 0x01 bounds, 0x02 tag, 0x03 seal, 0x12 load perm, 0x13 store perm, 0x15 store-cap perm.
- exc_valid  in  1  one-cycle pulse when the core takes a trap.
- exc_mcause  in  6  trap cause; 28 = CHERI, 4/6 = load/store misaligned.
- exc_mtval  in  32  trap value.
- chk_state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 REPORT.
- inj_cnt  out  CNT_W  injections seen.
- det_cnt  out  CNT_W  injections matched by a correct trap.
- miss_cnt  out  CNT_W  injections that timed out, failed, or trapped wrongly.
- mismatch_pulse  out  1  one-cycle pulse per miss.
- chk_fail  out  1  sticky; set on the first miss.

## Operation
- An internal register err_active_q delays err_active by one cycle. A rising edge is `err_active & ~err_active_q`.
- IDLE:
  - On a rising edge with err_enable=1: go to ARMED, increment inj_cnt, latch exp_cause/exp_cause_vld, clear timer.
  - Rising edges while ARMED or REPORT are ignored and not counted.
- ARMED: timer increments each cycle. Events are evaluated in this priority order, first match wins:
  1. err_failed=1: miss.
  2. exc_valid=1 with acceptable cause: hit.
  3. exc_valid=1 with any other cause: miss.
  4. timer == TIMEOUT-1: miss.
- Acceptable cause:
  - exc_mcause==28 (the CHERI-code check applies, see Configuration), or
  - exc_mcause∈{4,6} with exp_cause_vld=0 (alignment injection).
- Hit: det_cnt++, go to REPORT.
- Miss: miss_cnt++, mismatch_pulse=1, chk_fail=1, go to REPORT.
- REPORT: lasts one cycle, then IDLE once err_active=0; otherwise it stays in REPORT.
- err_enable=0 in any state: go to IDLE at the next edge. No counter changes, and any pending injection is dropped silently.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (rst=1 at an edge): all outputs 0, state IDLE, timer 0, err_active_q 0. Reset mid-ARMED discards the injection with no counter update.
- Counter, state and pulse updates are registered and visible the cycle after the triggering input edge.
- mismatch_pulse is high for exactly one cycle per miss.
- An exc_valid in the same cycle as the rising edge is not matched; matching starts the cycle after entering ARMED.
- A timeout fires on the TIMEOUT-th cycle in ARMED, when the timer reaches TIMEOUT-1.
- A single trap can retire at most one injection.

## Configuration
- CAP_ERR_SCOREBOARD_TVAL_EN defined: a cause-28 trap is acceptable only if exp_cause_vld=0 or exc_mtval[4:0]==exp_cause. A cause-code mismatch is a miss.
- Undefined: exc_mtval and exp_cause are ignored, and any cause-28 trap is a hit.

## Test plan
- Rise err_active with exp_cause=0x02; exc_valid with mcause=28, mtval[4:0]=0x02 three cycles later -> det_cnt=1, inj_cnt=1, chk_fail=0, IDLE after err_active falls.
- Injection, no trap for 64 cycles -> mismatch_pulse on cycle 64, miss_cnt=1, chk_fail=1.
- Injection; err_failed and exc_valid(28) in the same cycle -> counted as miss (err_failed priority), det_cnt=0.
- With TVAL_EN: exp_cause=0x12, trap mtval[4:0]=0x13 -> miss. Without TVAL_EN, the same stimulus -> hit.
- exp_cause_vld=0, trap mcause=6 -> hit; mcause=2 -> miss.
- Pulse rst mid-ARMED, then drop err_enable during a second injection -> all counters 0 after reset, no count from the dropped injection, state IDLE.
